load_store_unit: RTL and testbench

Memory-stage load/store sequencer sitting directly upstream of `data_cache`. Accepts one load or store request from the pipeline and translates it into cache-side accesses: one 4-byte read for loads, one byte write per cycle for stores. For loads it performs RISC-V width selection and sign/zero extension. It returns a single-cycle response to the pipeline.

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of data_cache: one 4-byte read per load, one byte write per store cycle.
// Optional feature: define LOAD_STORE_UNIT_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_op,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_cache_address,
  output logic [31:0]       o_cache_val,
  output logic              o_cache_op_type,
  input  logic [31:0]       i_cache_val
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        k_q, k_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        accept;
  logic        illegal;
  logic        misalign;
  logic        req_err;
  logic [1:0]  last_k;
  logic [31:0] load_val;

  assign accept  = i_req_valid && (state_q == IDLE);
  assign illegal = i_req_op ? (i_funct3 >= 3'd3)
                            : ((i_funct3 == 3'd3) || (i_funct3[2:1] == 2'b11));

`ifdef LOAD_STORE_UNIT_MISALIGN_TRAP_EN
  assign misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                    ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = illegal || misalign;

  // Index of the final byte of the store: SB 0, SH 1, SW 3.
  assign last_k = (funct3_q[1:0] == 2'b10) ? 2'd3 :
                  (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd0;

  always_comb begin
    load_val = 32'd0;
    case (funct3_q)
      3'd0:    load_val = {{24{i_cache_val[7]}}, i_cache_val[7:0]};
      3'd1:    load_val = {{16{i_cache_val[15]}}, i_cache_val[15:0]};
      3'd2:    load_val = i_cache_val;
      3'd4:    load_val = {24'd0, i_cache_val[7:0]};
      3'd5:    load_val = {16'd0, i_cache_val[15:0]};
      default: load_val = 32'd0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    k_d      = k_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d = i_funct3;
          wdata_d  = i_wdata;
          k_d      = 2'd0;
          rdata_d  = 32'd0;
          err_d    = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            // The cache address only moves for real accesses; errors leave it untouched.
            addr_d  = i_addr;
            state_d = i_req_op ? STORE : LOAD;
          end
        end
      end
      LOAD: begin
        rdata_d = load_val;
        state_d = RESP;
      end
      STORE: begin
        if (k_q == last_k) begin
          state_d = RESP;
        end else begin
          k_d    = k_q + 2'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over every transition.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      k_q      <= 2'd0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign o_req_ready     = (state_q == IDLE);
  assign o_resp_valid    = (state_q == RESP);
  assign o_rdata         = (state_q == RESP) ? rdata_q : 32'd0;
  assign o_err           = (state_q == RESP) ? err_q : 1'b0;
  assign o_cache_address = addr_q;
  assign o_cache_op_type = (state_q == STORE);
  assign o_cache_val     = (state_q == STORE) ? {24'd0, wdata_q[{k_q, 3'b000} +: 8]} : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level memory model predicts cache writes and responses.
// Honours LOAD_STORE_UNIT_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_op;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_resp_valid;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [31:0] o_cache_address;
  logic [31:0] o_cache_val;
  logic        o_cache_op_type;
  logic [31:0] i_cache_val;

  load_store_unit #(.ADDR_W(32)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_op        (i_req_op),
    .i_funct3        (i_funct3),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .o_resp_valid    (o_resp_valid),
    .o_rdata         (o_rdata),
    .o_err           (o_err),
    .o_cache_address (o_cache_address),
    .o_cache_val     (o_cache_val),
    .o_cache_op_type (o_cache_op_type),
    .i_cache_val     (i_cache_val)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int unsigned at; } resp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int unsigned at; } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] env_mem [logic [31:0]];
  int n_cmp = 0;
  int n_bad = 0;
  bit ready_due = 1'b0;

  function automatic logic [7:0] dflt(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] env_rd(logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cache stand-in: commits the byte written this cycle, then presents the 4 bytes at the current address.
  always @(negedge i_clk) begin
    if (o_cache_op_type) env_mem[o_cache_address] = o_cache_val[7:0];
    i_cache_val = {env_rd(o_cache_address + 32'd3), env_rd(o_cache_address + 32'd2),
                   env_rd(o_cache_address + 32'd1), env_rd(o_cache_address)};
  end

  // Monitor: pops expectations whenever the DUT shows a response or a cache write.
  always @(negedge i_clk) begin
    if (cyc > 0) begin
      if (ready_due) begin
        check("ready_after_resp", 32'(o_req_ready), 32'd1);
        ready_due = 1'b0;
      end
      if (o_resp_valid) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 32'(o_resp_valid), 32'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          check("resp_cycle", cyc, e.at);
          check("resp_rdata", o_rdata, e.rdata);
          check("resp_err", 32'(o_err), 32'(e.err));
          check("ready_during_resp", 32'(o_req_ready), 32'd0);
          ready_due = 1'b1;
        end
      end
      if (o_cache_op_type) begin
        if (wr_q.size() == 0) begin
          check("spurious_write", 32'(o_cache_op_type), 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("write_cycle", cyc, w.at);
          check("write_addr", o_cache_address, w.addr);
          check("write_val", o_cache_val, {24'd0, w.data});
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_ready", 32'(o_req_ready), 32'd1);
    check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_cache_address", o_cache_address, 32'd0);
    check("rst_cache_val", o_cache_val, 32'd0);
    check("rst_cache_op_type", 32'(o_cache_op_type), 32'd0);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge i_clk);
      i_req_valid = 1'b0;
    end
  endtask

  // Issues one request; while the DUT is busy it drives random junk (possibly valid) that must be ignored.
  // keep limits how many store bytes are expected (used when reset cuts a store short).
  task automatic issue(bit op, bit [2:0] f3, logic [31:0] addr, logic [31:0] wdata, int keep = 4);
    bit          got = 1'b0;
    bit          illegal;
    bit          mis = 1'b0;
    int          size;
    int unsigned acc;
    logic [31:0] w;
    logic [31:0] r;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge i_clk);
      if (o_req_ready) begin
        got = 1'b1;
      end else begin
        i_req_valid = 1'($urandom);
        i_req_op    = 1'($urandom);
        i_funct3    = 3'($urandom);
        i_addr      = $urandom;
        i_wdata     = $urandom;
      end
    end
    if (!got) begin
      check("ready_timeout", 32'(o_req_ready), 32'd1);
      return;
    end
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_funct3    = f3;
    i_addr      = addr;
    i_wdata     = wdata;
    acc = cyc + 1;

    illegal = op ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
    size    = 1 << f3[1:0];
`ifdef LOAD_STORE_UNIT_MISALIGN_TRAP_EN
    mis = (addr % size) != 0;
`endif
    if (illegal || mis) begin
      resp_q.push_back('{rdata: 32'd0, err: 1'b1, at: acc});
    end else if (!op) begin
      w = {ref_rd(addr + 32'd3), ref_rd(addr + 32'd2), ref_rd(addr + 32'd1), ref_rd(addr)};
      case (f3)
        3'd0:    r = 32'($signed(w[7:0]));
        3'd1:    r = 32'($signed(w[15:0]));
        3'd4:    r = 32'(w[7:0]);
        3'd5:    r = 32'(w[15:0]);
        default: r = w;
      endcase
      resp_q.push_back('{rdata: r, err: 1'b0, at: acc + 1});
    end else begin
      for (int i = 0; i < size && i < keep; i++) begin
        ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        wr_q.push_back('{addr: addr + 32'(i), data: wdata[8*i +: 8], at: acc + 32'(i)});
      end
      if (keep >= size) resp_q.push_back('{rdata: 32'd0, err: 1'b0, at: acc + 32'(size)});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_op    = 1'b0;
    i_funct3    = 3'd0;
    i_addr      = 32'd0;
    i_wdata     = 32'd0;
    repeat (2) @(negedge i_clk);
    check_reset_outputs();
    i_rst = 1'b0;
    idle(2);

    issue(1'b1, 3'd2, 32'h0000_0100, 32'hA1B2_C3D4);
    issue(1'b0, 3'd0, 32'h0000_0101, 32'd0);
    issue(1'b0, 3'd4, 32'h0000_0101, 32'd0);
    issue(1'b0, 3'd1, 32'h0000_0102, 32'd0);
    issue(1'b1, 3'd0, 32'h0000_0103, 32'h0000_0055);
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0);
    issue(1'b0, 3'd3, 32'h0000_0200, 32'd0);
    issue(1'b1, 3'd5, 32'h0000_0200, 32'hDEAD_BEEF);
    issue(1'b0, 3'd2, 32'h0000_0102, 32'd0);
    issue(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1357_9BDF);
    issue(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0);
    idle(3);

    // Reset in the second write cycle of a word store: only two bytes land.
    issue(1'b1, 3'd2, 32'h0000_0300, 32'h1122_3344, 2);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_outputs();
    i_rst = 1'b0;
    issue(1'b0, 3'd2, 32'h0000_0300, 32'd0);

    repeat (300) begin
      case ($urandom_range(0, 3))
        0:       base = 32'hFFFF_FFF8;
        1:       base = 32'h0000_0000;
        default: base = 32'h0000_0100;
      endcase
      issue(1'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)),
            base + $urandom_range(0, 15), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(10);
    check("resp_q_drained", resp_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
